// File: rtl/bus_arb2.sv
// bus_arb2: two-master round-robin arbiter and sequencer for the 16-bit
// register bus (baddr/bwr/bstrobe/bwrdata/brddata) feeding the zreg/zror
// slaves. Master 0 is the PS GPIO bridge, master 1 is a PL-side engine.
//
// Every transaction takes four cycles: an IDLE cycle that samples the
// requests, then SETUP, STROBE and DONE. Every output is registered.
//
// Ports:
//   clk, rst_n                 bus clock, asynchronous active-low reset
//   req0/wr0/addr0/wdata0      master 0 request, direction, address, data
//   ack0/rdata0                master 0 one-cycle done pulse, read data
//   req1/wr1/addr1/wdata1      master 1 request, direction, address, data
//   ack1/rdata1                master 1 one-cycle done pulse, read data
//   baddr/bwr/bstrobe/bwrdata  bus address, write enable, strobe, write data
//   brddata                    bus read data (wired-OR of the slaves)
//   gnt                        one-hot owner of the current transaction
//   nxfer0/nxfer1              completed-transaction counters, wrap at 0xffff
module bus_arb2 #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] baddr,
  output logic          bwr,
  output logic          bstrobe,
  output logic [DW-1:0] bwrdata,
  input  logic [DW-1:0] brddata,
  output logic [1:0]    gnt,
  output logic [15:0]   nxfer0,
  output logic [15:0]   nxfer1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic        last_gnt;   // index of the master served most recently
  logic        owner;      // index of the master owning this transaction
  logic        win_sel;    // master chosen if a grant happens this cycle
  logic [15:0] xfer_cnt0;
  logic [15:0] xfer_cnt1;

  // A lone requester wins outright; on a tie the master that was not
  // served last wins. last_gnt resets to 1 so master 0 takes the first tie.
  assign win_sel = (req0 && req1) ? ~last_gnt : req1;

  assign nxfer0 = xfer_cnt0;
  assign nxfer1 = xfer_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      gnt       <= 2'b00;
      baddr     <= '0;
      bwrdata   <= '0;
      bwr       <= 1'b0;
      bstrobe   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      xfer_cnt0 <= '0;
      xfer_cnt1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        // IDLE -> SETUP: requests are sampled only here; the winner's
        // address, data and direction go straight onto the bus.
        IDLE: begin
          if (req0 || req1) begin
            owner    <= win_sel;
            last_gnt <= win_sel;
            gnt      <= win_sel ? 2'b10 : 2'b01;
            baddr    <= win_sel ? addr1 : addr0;
            bwrdata  <= win_sel ? wdata1 : wdata0;
            bwr      <= win_sel ? wr1 : wr0;
            state    <= SETUP;
          end
        end
        // SETUP -> STROBE: address/data have had a full cycle to settle.
        SETUP: begin
          bstrobe <= 1'b1;
          state   <= STROBE;
        end
        // STROBE -> DONE: read data is captured on this edge and the
        // owner is acknowledged and counted.
        STROBE: begin
          bstrobe <= 1'b0;
          bwr     <= 1'b0;
          if (!bwr) begin
            if (owner) rdata1 <= brddata;
            else       rdata0 <= brddata;
          end
          if (owner) begin
            ack1      <= 1'b1;
            xfer_cnt1 <= xfer_cnt1 + 16'd1;
          end else begin
            ack0      <= 1'b1;
            xfer_cnt0 <= xfer_cnt0 + 16'd1;
          end
          state <= DONE;
        end
        // DONE -> IDLE: ownership is released; baddr/bwrdata keep their
        // last values.
        DONE: begin
          gnt   <= 2'b00;
          state <= IDLE;
        end
        default: begin
          bstrobe <= 1'b0;
          bwr     <= 1'b0;
          gnt     <= 2'b00;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Testbench for bus_arb2: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_bus_arb2;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, bwr, bstrobe;
  logic [DW-1:0] rdata0, rdata1, bwrdata, brddata;
  logic [AW-1:0] baddr;
  logic [1:0]    gnt;
  logic [15:0]   nxfer0, nxfer1;

  always #5 clk = ~clk;

  bus_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .baddr(baddr), .bwr(bwr), .bstrobe(bstrobe), .bwrdata(bwrdata), .brddata(brddata),
    .gnt(gnt), .nxfer0(nxfer0), .nxfer1(nxfer1)
  );

  // Slave register file, indexed by the low address bits.
  logic [15:0] smem [16];
  assign brddata = smem[baddr[3:0]];

  // Reference model: one transaction in flight, aged in cycles since grant.
  int          cyc = 0;
  int          gcyc = 0;
  bit          busy = 0;
  bit          mlast = 1;
  bit          mown = 0;
  bit          mwr = 0;
  logic [15:0] maddr = '0, mwdata = '0;
  logic [15:0] mmem [16];
  logic [15:0] erd [2];
  logic [15:0] ecnt [2];
  int          p0 = 0, p1 = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; mlast = 1; mown = 0; mwr = 0; maddr = '0; mwdata = '0;
    erd[0] = '0; erd[1] = '0; ecnt[0] = '0; ecnt[1] = '0;
  endtask

  task automatic model_edge();
    int a;
    cyc++;
    if (!rst_n) return;
    if (busy) begin
      a = cyc - gcyc;
      if (a == 2) begin
        if (mwr) mmem[maddr[3:0]] = mwdata;
        else     erd[mown] = mmem[maddr[3:0]];
        ecnt[mown] = ecnt[mown] + 16'd1;
      end else if (a == 3) begin
        busy = 0;
      end
    end else if (req0 || req1) begin
      if (req0 && req1) mown = ~mlast;
      else              mown = req1;
      mlast = mown;
      busy  = 1;
      gcyc  = cyc;
      mwr    = mown ? wr1 : wr0;
      maddr  = mown ? addr1 : addr0;
      mwdata = mown ? wdata1 : wdata0;
    end
  endtask

  task automatic compare_all();
    int a;
    logic [1:0] eg;
    a  = cyc - gcyc;
    eg = busy ? (mown ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt",     gnt,     eg);
    chk("bwr",     bwr,     busy && mwr && a <= 1);
    chk("bstrobe", bstrobe, busy && a == 1);
    chk("ack0",    ack0,    busy && a == 2 && !mown);
    chk("ack1",    ack1,    busy && a == 2 && mown);
    chk("baddr",   baddr,   maddr);
    chk("bwrdata", bwrdata, mwdata);
    chk("rdata0",  rdata0,  erd[0]);
    chk("rdata1",  rdata1,  erd[1]);
    chk("nxfer0",  nxfer0,  ecnt[0]);
    chk("nxfer1",  nxfer1,  ecnt[1]);
  endtask

  task automatic post(input int m, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (m == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic master_update();
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
    if (!req0 && $urandom_range(99) < p0) post(0, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
    if (!req1 && $urandom_range(99) < p1) post(1, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
  endtask

  task automatic cycle();
    @(negedge clk);
    if (bstrobe && bwr) smem[baddr[3:0]] = bwrdata;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    master_update();
  endtask

  task automatic wait_ack(input int m, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if ((m == 0 && ack0) || (m == 1 && ack1)) return;
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    p0 = 0; p1 = 0;
    for (int i = 0; i < budget; i++) begin
      if (!req0 && !req1 && !busy && gnt == 2'b00) return;
      cycle();
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [$];
    logic [1:0] prev_g;
    logic [1:0] exp_seq [6];
    for (int i = 0; i < 16; i++) begin
      smem[i] = 16'(i * 16'h0101);
      mmem[i] = 16'(i * 16'h0101);
    end
    model_reset();

    // Reset state
    do_reset();
    cycle();

    // Single write from master 0
    post(0, 1'b1, 16'h0003, 16'h1234);
    cycle();
    chk("t1_bwr_c1", bwr, 1); chk("t1_stb_c1", bstrobe, 0);
    cycle();
    chk("t1_bwr_c2", bwr, 1); chk("t1_stb_c2", bstrobe, 1);
    cycle();
    chk("t1_ack_c3", ack0, 1); chk("t1_stb_c3", bstrobe, 0); chk("t1_nxfer0", nxfer0, 1);
    cycle();
    post(0, 1'b0, 16'h0003, 16'h0000);
    wait_ack(0, 10);
    chk("t1_readback", rdata0, 16'h1234);
    cycle();

    // Read from master 1
    smem[1] = 16'hbeef; mmem[1] = 16'hbeef;
    post(1, 1'b0, 16'h0001, 16'h0000);
    cycle();
    chk("t2_bwr_c1", bwr, 0);
    cycle();
    chk("t2_brddata", brddata, 16'hbeef); chk("t2_bwr_c2", bwr, 0);
    cycle();
    chk("t2_ack1", ack1, 1); chk("t2_rdata1", rdata1, 16'hbeef); chk("t2_rdata0", rdata0, 16'h1234);
    drain(20);

    // Both masters requesting continuously from reset
    do_reset();
    p0 = 100; p1 = 100;
    post(0, 1'b1, 16'h0008, 16'haaaa);
    post(1, 1'b1, 16'h0009, 16'h5555);
    prev_g = 2'b00;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (gnt != 2'b00 && prev_g == 2'b00) seq.push_back(gnt);
      prev_g = gnt;
    end
    chk("t3_nxfer0", nxfer0, 3);
    chk("t3_nxfer1", nxfer1, 3);
    chk("t3_ngrants", seq.size(), 6);
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6 && i < seq.size(); i++) chk($sformatf("t3_gnt%0d", i), seq[i], exp_seq[i]);
    drain(40);

    // Counter wrap on master 0
    force dut.xfer_cnt0 = 16'hfffe;
    #1;
    release dut.xfer_cnt0;
    ecnt[0] = 16'hfffe;
    post(0, 1'b1, 16'h0004, 16'h0044);
    wait_ack(0, 10);
    chk("t4_ffff", nxfer0, 16'hffff);
    cycle();
    post(0, 1'b1, 16'h0004, 16'h0045);
    wait_ack(0, 10);
    chk("t4_wrap", nxfer0, 16'h0000);
    chk("t4_nxfer1", nxfer1, ecnt[1]);
    drain(20);

    // Reset during STROBE of a write; request held across reset
    post(0, 1'b1, 16'h0007, 16'h7777);
    cycle();
    cycle();
    chk("t5_in_strobe", bstrobe, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_stb", bstrobe, 0); chk("t5_rst_bwr", bwr, 0);
    chk("t5_rst_gnt", gnt, 0);     chk("t5_rst_ack", ack0, 0);
    chk("t5_rst_cnt", nxfer0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    wait_ack(0, 10);
    chk("t5_rerun_cnt", nxfer0, 1);
    drain(20);

    // Master 1 arrives during master 0's SETUP; master 0 re-requests at once
    post(0, 1'b1, 16'h0005, 16'h5a5a);
    cycle();
    post(1, 1'b1, 16'h0006, 16'h6666);
    wait_ack(0, 10);
    post(0, 1'b1, 16'h0005, 16'h1111);
    cycle();
    cycle();
    chk("t6_gnt_m1", gnt, 2'b10);
    drain(30);

    // Randomized traffic
    p0 = 60; p1 = 60;
    for (int i = 0; i < 1500; i++) cycle();
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arb2.md
Name: bus_arb2

Overview:
- Two-master arbiter and sequencer for the 16-bit register "bus" (baddr, bwr, bstrobe, bwrdata, brddata) that feeds the zreg/zror register slaves.
- Master 0 is the PS GPIO bridge; master 1 is a PL-side engine (DMA/sequencer).
- Each master posts a single read or write request. The arbiter picks one master round-robin and runs the standard setup/strobe bus cycle. It then returns read data and a one-cycle ack to the winning master.

Parameters:
- AW, 16, bus address width.
- DW, 16, bus data width.

Ports:
- clk  in  1  bus clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  master 0 request (level); held until ack0.
- wr0  in  1  master 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  AW  master 0 address; stable while req0 is high.
- wdata0  in  DW  master 0 write data; stable while req0 is high.
- ack0  out  1  one-cycle done pulse to master 0.
- rdata0  out  DW  read data for master 0; valid when ack0 is high, held until master 0's next ack.
- req1, wr1, addr1, wdata1, ack1, rdata1: same as above, for master 1.
- baddr  out  AW  bus address.
- bwr  out  1  bus write enable.
- bstrobe  out  1  bus strobe.
- bwrdata  out  DW  bus write data.
- brddata  in  DW  bus read data (wired-OR of slaves).
- gnt  out  2  one-hot owner of the current transaction; 00 when idle.
- nxfer0, nxfer1  out  16 each  completed-transaction counters per master.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: baddr, bwrdata, rdata0/1, gnt, counters, bwr, bstrobe, ack0/1.
  - last_gnt is set to 1, so master 0 wins the first tie.
  - Release is synchronous to clk.
- All outputs are registered; there are no combinational paths from req* to outputs.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that is not last_gnt.
  - On grant, update last_gnt and latch the winner's addr/wdata/wr into baddr/bwrdata/bwr.
  - Set gnt one-hot and go to SETUP.
- SETUP (bus cycle 1):
  - baddr, bwrdata and bwr (if write) are driven; bstrobe=0.
  - Go to STROBE.
- STROBE (bus cycle 2):
  - bstrobe=1; bwr stays at its SETUP value.
  - Read: brddata is captured into the granted rdataN at the end of this cycle.
  - Write: rdataN is unchanged.
  - Go to DONE.
- DONE:
  - bstrobe=0, bwr=0; ackN=1 for this single cycle.
  - nxferN increments, wrapping 0xffff to 0x0000.
  - gnt clears to 00 entering IDLE; baddr/bwrdata hold their last values.
  - Go to IDLE.
- Latency: req sampled high in IDLE at cycle C gives:
  - addr on bus in C+1;
  - bstrobe in C+2;
  - ack in C+3.
  Back-to-back transactions therefore take 4 cycles each.
- Master obligation:
  - Deassert req at the edge that samples ack high, so req is low in the following IDLE cycle.
  - req still high in IDLE is treated as a new request.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1. No master waits more than one transaction.
- Request changes while not IDLE are ignored. Request lines are sampled only in IDLE.
- A req dropped before its ack is a protocol violation. A transaction already granted completes anyway, and the ack is still issued.
- Reset mid-transaction:
  - bstrobe/bwr drop immediately.
  - No ack is issued and no counter increments.
  - The pending req is re-arbitrated after reset release.
- Illegal FSM encoding goes to IDLE with all strobes 0.

Test Plan:
1. Reset, then req0: wr0=1, addr0=0x0003, wdata0=0x1234.
   - Required: bwr=1 in C+1 and C+2; bstrobe=1 only in C+2; ack0 in C+3; nxfer0=1.
   - Zreg 0x0003 then reads 0x1234.
2. Read, req1: wr1=0, addr1=0x0001.
   - Required: brddata=0xbeef during strobe; rdata1=0xbeef with ack1 in C+3; bwr=0 throughout; rdata0 unchanged.
3. Both req high in the same cycle from reset, each held for 6 transactions.
   - Required: gnt sequence 01,10,01,10,01,10; nxfer0=nxfer1=3 after 24 cycles; no idle gaps beyond 1 IDLE cycle per transaction.
4. Counter wrap: preload via 65535 master-0 writes (or force), then one more.
   - Required: nxfer0 wraps from 0xffff to 0x0000; nxfer1 is unaffected.
5. Reset mid-operation: assert rst_n=0 during STROBE of a write.
   - Required: bstrobe, bwr, gnt and ack go to 0 asynchronously; nxfer=0. After release with req held, the transaction reruns and acks normally.
6. req1 rises while master 0's transaction is in SETUP.
   - Required: master 1 is not granted until the IDLE following ack0; then it gets gnt=10 even if req0 is reasserted (round-robin).
